// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage driving a req/ack data bus, stalling upstream while an access is outstanding.
// State advances on the falling clock edge; rst is asynchronous and active-low.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic [31:0] in_ALUresult,
  input  logic [31:0] in_writeData,
  input  logic [4:0]  in_writeReg,
  input  logic [1:0]  in_WB,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] M_ALUresult,
  output logic [31:0] M_readData,
  output logic [4:0]  M_writeReg,
  output logic [1:0]  M_WB,
  output logic        fault
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          memop, misaligned;
  assign memop       = in_valid & (in_MemRead | in_MemWrite);
  assign misaligned  = in_ALUresult[1:0] != 2'b00;
  assign stall       = (state == IDLE && memop) || state == BUSY;
  assign M_ALUresult = in_ALUresult;
  assign M_writeReg  = in_writeReg;
  // A faulted instruction reaches writeback as a bubble.
  assign M_WB        = (stall || (state == DONE && fault)) ? 2'b00 : in_WB;
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      M_readData <= '0;
      fault      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (memop) begin
          if (misaligned) begin
            state <= DONE;
            fault <= 1'b1;
          end else begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= in_MemWrite & ~in_MemRead;
            mem_addr  <= in_ALUresult;
            mem_wdata <= in_writeData;
            cnt       <= '0;
          end
        end
        // An ack arriving on the timeout edge still completes cleanly.
        BUSY: if (mem_ack) begin
          state   <= DONE;
          mem_req <= 1'b0;
          if (!mem_we) M_readData <= mem_rdata;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state   <= DONE;
          mem_req <= 1'b0;
          fault   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          fault <= 1'b0;
        end
      endcase
    end
  end
endmodule
